// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-memory access stage. Runs one load or store per request
//                over a valid/ready memory port, lane-aligns store data and
//                extends load data; reports misaligned, illegal and timed-out
//                accesses with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [1:0]  lsu_err,
  output logic [31:0] ReadData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] C_ERR_OK  = 2'b00;
  localparam logic [1:0] C_ERR_MIS = 2'b01;
  localparam logic [1:0] C_ERR_ILL = 2'b10;
  localparam logic [1:0] C_ERR_TO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_off;
  logic [2:0]    r_f3;
  logic          r_load;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [1:0]    r_err;
  logic [31:0]   r_rdata;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;

  logic          w_start;
  logic          w_illegal;
  logic          w_misaligned;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_lane;
  logic [31:0]   w_ext;

  assign w_start = lsu_valid & (MemRead | MemWrite);

  // Classify the incoming request: illegal size/direction, then alignment
  always_comb begin
    w_illegal = 1'b0;
    if (MemRead & MemWrite) begin
      w_illegal = 1'b1;
    end else if (MemRead) begin
      w_illegal = !(Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010 ||
                    Funct3 == 3'b100 || Funct3 == 3'b101);
    end else begin
      w_illegal = !(Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010);
    end
    w_misaligned = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                   ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
  end

  // Replicate store data across lanes and build byte enables from the offset
  always_comb begin
    w_wdata = WriteData;
    w_wstrb = 4'b1111;
    case (Funct3[1:0])
      2'b00: begin
        w_wdata = {4{WriteData[7:0]}};
        w_wstrb = 4'b0001 << ALUResult[1:0];
      end
      2'b01: begin
        w_wdata = {2{WriteData[15:0]}};
        w_wstrb = 4'b0011 << ALUResult[1:0];
      end
      default: begin
        w_wdata = WriteData;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Select the addressed lane of the read word and sign/zero-extend it
  always_comb begin
    w_lane = mem_rdata >> {r_off, 3'b000};
    case (r_f3)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  // Access sequencer: IDLE -> REQ -> RESP -> IDLE, rejected requests skip REQ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_off   <= 2'b00;
      r_f3    <= 3'b000;
      r_load  <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= C_ERR_OK;
      r_rdata <= 32'd0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'b0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_off  <= ALUResult[1:0];
            r_f3   <= Funct3;
            r_load <= MemRead & ~MemWrite;
            if (w_illegal) begin
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_err   <= C_ERR_ILL;
            end else if (w_misaligned) begin
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_err   <= C_ERR_MIS;
            end else begin
              r_state <= S_REQ;
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_we    <= MemWrite;
              r_addr  <= {ALUResult[31:2], 2'b00};
              r_wdata <= MemWrite ? w_wdata : 32'd0;
              r_wstrb <= MemWrite ? w_wstrb : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            if (r_load) begin
              r_rdata <= w_ext;
            end
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_state <= S_RESP;
            r_done  <= 1'b1;
            r_err   <= C_ERR_OK;
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1))) begin
            // Withdraw the request; the memory side must tolerate this
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_state <= S_RESP;
            r_done  <= 1'b1;
            r_err   <= C_ERR_TO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_err   <= C_ERR_OK;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lsu_busy  = (r_state != S_IDLE);
  assign lsu_done  = r_done;
  assign lsu_err   = r_err;
  assign ReadData  = r_rdata;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Scoreboard bench for load_store_unit. Stimulus pushes the
//                expected completion and memory transaction; independent
//                monitors pop and compare on lsu_done and on mem handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] ALUResult = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        lsu_busy;
  logic        lsu_done;
  logic [1:0]  lsu_err;
  logic [31:0] ReadData;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rd;
  } done_exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_exp_t;

  done_exp_t done_q[$];
  mem_exp_t  mem_q[$];

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] last_rd = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .lsu_valid (lsu_valid),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .lsu_busy  (lsu_busy),
    .lsu_done  (lsu_done),
    .lsu_err   (lsu_err),
    .ReadData  (ReadData),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (lsu_done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got err %0b with nothing expected", lsu_err);
      end else begin
        done_exp_t e;
        e = done_q.pop_front();
        chk("done_err", {62'd0, lsu_err}, {62'd0, e.err});
        chk("read_data", {32'd0, ReadData}, {32'd0, e.rd});
      end
    end
  end

  // Memory-side monitor: each accepted handshake must match the expected beat
  always @(negedge clk) begin
    if (mem_req === 1'b1 && mem_ready === 1'b1) begin
      if (mem_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_mem: addr 0x%0h with nothing expected", mem_addr);
      end else begin
        mem_exp_t m;
        m = mem_q.pop_front();
        chk("mem_we", {63'd0, mem_we}, {63'd0, m.we});
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, m.addr});
        chk("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, m.wstrb});
        if (m.we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m.wdata});
      end
    end
  end

  // One request; delay<0 means memory never answers. accept=0 for rejected requests.
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int delay, input logic [31:0] rdata,
                     input bit accept, input logic [1:0] exp_err,
                     input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                     input logic [31:0] exp_rd);
    done_exp_t d;
    mem_exp_t  m;
    int        cnt;
    @(posedge clk); #1;
    lsu_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
    ALUResult = addr; WriteData = wd;
    d.err = exp_err; d.rd = exp_rd;
    done_q.push_back(d);
    if (accept && delay >= 0) begin
      m.we = wr; m.addr = {addr[31:2], 2'b00}; m.wdata = exp_wdata; m.wstrb = exp_wstrb;
      mem_q.push_back(m);
    end
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    if (!accept) begin
      chk("reject_done_next", {62'd0, lsu_done, mem_req}, {62'd0, 1'b1, 1'b0});
    end else begin
      chk("req_start", {63'd0, mem_req}, 64'd1);
      if (delay >= 0) begin
        repeat (delay) begin
          @(posedge clk); #1;
        end
        mem_ready = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("done_after_ready", {62'd0, lsu_done, mem_req}, {62'd0, 1'b1, 1'b0});
      end else begin
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 20) begin
          cnt++;
          @(posedge clk); #1;
        end
        chk("timeout_req_cycles", 64'(cnt), 64'd4);
        chk("timeout_done", {63'd0, lsu_done}, 64'd1);
      end
    end
    @(posedge clk); #1;
    chk("idle_after", {63'd0, lsu_busy}, 64'd0);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset_outputs",
        {lsu_busy, lsu_done, lsu_err, mem_req, mem_we, mem_wstrb, mem_addr[15:0], mem_wdata[15:0], ReadData[15:0]},
        64'd0);
    chk("reset_hi_words", {mem_addr[31:16], mem_wdata[31:16], ReadData[31:16]}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //   rd wr f3 addr data delay rdata accept err wdata wstrb exp_rd
    run(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 32'h0, 1, 2'b00, 32'hDEADBEEF, 4'b1111, last_rd);
    run(1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80FF7F01, 1, 2'b00, 32'h0, 4'b0000, 32'hFFFFFF80);
    run(1, 0, 3'b100, 32'h203, 32'h0, 2, 32'h80FF7F01, 1, 2'b00, 32'h0, 4'b0000, 32'h00000080);
    run(1, 0, 3'b001, 32'h202, 32'h0, 0, 32'h80FF7F01, 1, 2'b00, 32'h0, 4'b0000, 32'hFFFF80FF);
    run(1, 0, 3'b101, 32'h202, 32'h0, 1, 32'h80FF7F01, 1, 2'b00, 32'h0, 4'b0000, 32'h000080FF);
    run(1, 0, 3'b000, 32'h201, 32'h0, 0, 32'h80FF7F01, 1, 2'b00, 32'h0, 4'b0000, 32'h0000007F);
    run(1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h80FF7F01, 1, 2'b00, 32'h0, 4'b0000, 32'h80FF7F01);
    last_rd = 32'h80FF7F01;
    run(0, 1, 3'b000, 32'h101, 32'h000000AB, 1, 32'h0, 1, 2'b00, 32'hABABABAB, 4'b0010, last_rd);
    run(0, 1, 3'b001, 32'h102, 32'h00001234, 0, 32'h0, 1, 2'b00, 32'h12341234, 4'b1100, last_rd);
    // rejected requests: no memory traffic, ReadData unchanged
    run(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 0, 2'b01, 32'h0, 4'b0000, last_rd);
    run(1, 0, 3'b011, 32'h200, 32'h0, 0, 32'h0, 0, 2'b10, 32'h0, 4'b0000, last_rd);
    run(1, 1, 3'b010, 32'h200, 32'h0, 0, 32'h0, 0, 2'b10, 32'h0, 4'b0000, last_rd);
    run(0, 1, 3'b100, 32'h200, 32'h0, 0, 32'h0, 0, 2'b10, 32'h0, 4'b0000, last_rd);
    run(0, 1, 3'b001, 32'h103, 32'h0, 0, 32'h0, 0, 2'b01, 32'h0, 4'b0000, last_rd);

    // strobe with no direction is ignored
    @(posedge clk); #1;
    lsu_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    chk("ignored_valid", {62'd0, lsu_busy, mem_req}, 64'd0);

    // timeout: memory never answers
    run(1, 0, 3'b010, 32'h200, 32'h0, -1, 32'h0, 1, 2'b11, 32'h0, 4'b0000, last_rd);

    // reset asserted mid-request
    @(posedge clk); #1;
    lsu_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h200;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    chk("midreset_req_before", {63'd0, mem_req}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midreset_drop", {61'd0, mem_req, lsu_busy, lsu_done}, 64'd0);
    chk("midreset_readdata", {32'd0, ReadData}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    MemRead = 1'b0;
    last_rd = 32'd0;
    run(1, 0, 3'b010, 32'h200, 32'h0, 1, 32'h80FF7F01, 1, 2'b00, 32'h0, 4'b0000, 32'h80FF7F01);

    repeat (3) @(posedge clk);
    #1;
    chk("done_queue_empty", 64'(done_q.size()), 64'd0);
    chk("mem_queue_empty", 64'(mem_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
